id_hazard_scoreboard: RTL and testbench
=======================================

// Module: id_hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding unit for the ID stage. It supersedes the fixed 3-stage, compare-only stall check.
//  - Tracks every in-flight register write in a shift-register scoreboard, one entry per post-ID stage (EX..WB).
//  - Each entry carries a result-ready countdown, so multi-cycle ops (load, MUL) are handled.
//  - Produces per-source forwarding selects, a stall only when a value is not yet forwardable, and a stall perf counter.
// PARAMETERS
//  NUM_REGS    32  architectural registers; index 0 is hardwired zero
//  IDX_W       5   register index width, $clog2(NUM_REGS)
//  NUM_SRC     2   source operands checked per instruction
//  PIPE_DEPTH  3   tracked stages after ID; stage 1=EX ... stage PIPE_DEPTH=WB
//  LAT_W       2   width of issue_lat
//  FWD_W       2   forwarding select width, $clog2(PIPE_DEPTH+1)
// PORTS
//  clk           in   1              system clock
//  rst           in   1              asynchronous, active-high reset
//  issue_valid   in   1              valid instruction in ID this cycle
//  issue_reg_wr  in   1              instruction writes rd
//  issue_rd      in   IDX_W          destination register index
//  issue_lat     in   LAT_W          cycles after entering EX until the result is forwardable (1=ALU, 2=load/MUL)
//  src_idx       in   NUM_SRC*IDX_W  source register indices; src i at [i*IDX_W +: IDX_W]
//  src_used      in   NUM_SRC        source i is actually read
//  flush         in   1              kill the instruction in ID (taken branch/jump)
//  ex_hold       in   1              back end frozen this cycle
//  stall         out  1              hold ID/IF; insert a bubble into EX
//  pc_en         out  1              = ~stall
//  if_id_en      out  1              = ~stall
//  fwd_sel       out  NUM_SRC*FWD_W  0=regfile, k=forward from stage k
//  stall_cnt     out  32             saturating count of stall cycles
//  lat_err       out  1              sticky: issue_lat==0 or issue_lat>PIPE_DEPTH was seen
// BEHAVIOUR
//  - Entry e[k], k=1..PIPE_DEPTH, holds {v, rd, rem}.
//  - rst asserted: all v=0, rem=0, stall_cnt=0, lat_err=0. Hence stall=0, pc_en=if_id_en=1, fwd_sel=0.
//  - Reset mid-operation discards every in-flight entry immediately.
//  - Match for source i:
//    - src_used[i], src_idx!=0, e[k].v and e[k].rd==src_idx.
//    - The youngest (smallest k) match wins.
//    - No match: fwd_sel=0.
//  - Hazard for source i: the winning entry has rem!=0. Its value is not yet produced; fwd_sel still reports k.
//  - stall = ~flush & (ex_hold | (issue_valid & any source hazard)). Purely combinational from entries and inputs.
//  - Each rising clk edge with ex_hold=0:
//    - e[k+1] <= e[k] for k<PIPE_DEPTH; the entry leaving WB is dropped, since the regfile holds it from then on.
//    - rem decrements, saturating at 0, as the entry moves.
//    - e[1] <= {1, issue_rd, issue_lat-1} when issue_valid & issue_reg_wr & issue_rd!=0 & ~stall & ~flush.
//    - Otherwise e[1] <= bubble (v=0).
//  - ex_hold=1: entries and rem are frozen. stall=1 unless flush is asserted.
//  - issue_lat==0 is treated as 1; issue_lat>PIPE_DEPTH is clamped to PIPE_DEPTH. Either case sets lat_err, which clears only on rst.
//  - stall_cnt increments on every cycle with stall=1 and holds at 32'hFFFF_FFFF.
//  - flush and hazard in the same cycle: flush wins.
//    - stall=0, the ID instruction is dropped, a bubble enters EX, and stall_cnt is unchanged.
//  - Regfile write-then-read in the same cycle is not this block's concern. The WB stage (k=PIPE_DEPTH) is still forwarded.
//  - Latency: fwd_sel and stall are valid in the same cycle as src_idx. The scoreboard updates one cycle after issue.
// TESTING
//  1. ALU chain: add x5 (lat1), then sub x6,x5,x5 next cycle -> stall=0, fwd_sel[0]=fwd_sel[1]=1.
//  2. Load-use: lw x7 (lat2), then add x8,x7,x0.
//     - Cycle 1: stall=1, fwd_sel[0]=1. Cycle 2: stall=0, fwd_sel[0]=2.
//     - stall_cnt=1, and e[1] held a bubble for one cycle.
//  3. Multiple writers: x3 in stage 3 and stage 1 (both rem=0), then read x3 -> fwd_sel=1 (youngest).
//  4. Writes to x0 or src_used=0 -> never matched, fwd_sel=0, stall=0. Four cycles after x9 issues, reading x9 -> fwd_sel=0 (regfile).
//  5. flush=1 together with a load-use hazard -> stall=0, no entry added, stall_cnt unchanged.
//     - ex_hold=1 for 3 cycles -> stall=1 each cycle, entries frozen, stall_cnt+=3.
//  6. Assert rst mid-stream with 3 valid entries -> all fwd_sel=0, stall=0, stall_cnt=0 at once, without waiting for a clk edge.
//     - issue_lat=3 with PIPE_DEPTH=2 after reset -> lat_err=1 and stays 1.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage hazard scoreboard with per-entry result countdown and forwarding selects
module id_hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int LAT_W      = 2,
    parameter int FWD_W      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_reg_wr,
    input  logic [IDX_W-1:0]           issue_rd,
    input  logic [LAT_W-1:0]           issue_lat,
    input  logic [NUM_SRC*IDX_W-1:0]   src_idx,
    input  logic [NUM_SRC-1:0]         src_used,
    input  logic                       flush,
    input  logic                       ex_hold,
    output logic                       stall,
    output logic                       pc_en,
    output logic                       if_id_en,
    output logic [NUM_SRC*FWD_W-1:0]   fwd_sel,
    output logic [31:0]                stall_cnt,
    output logic                       lat_err
);

    localparam logic [LAT_W:0] LP_DEPTH = (LAT_W+1)'(PIPE_DEPTH);

    logic                   r_v   [1:PIPE_DEPTH];
    logic [IDX_W-1:0]       r_rd  [1:PIPE_DEPTH];
    logic [LAT_W-1:0]       r_rem [1:PIPE_DEPTH];
    logic [31:0]            r_stall_cnt;
    logic                   r_lat_err;

    logic [FWD_W-1:0]       w_sel [NUM_SRC];
    logic [NUM_SRC-1:0]     w_src_haz;
    logic                   w_stall;
    logic                   w_push;
    logic                   w_lat_zero;
    logic                   w_lat_high;
    logic [LAT_W-1:0]       w_lat_eff;
    logic [LAT_W-1:0]       w_rem_new;

    // Scan oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel[i]     = '0;
            w_src_haz[i] = 1'b0;
            for (int k = PIPE_DEPTH; k >= 1; k--) begin
                if (src_used[i] && (src_idx[i*IDX_W +: IDX_W] != '0) && r_v[k] &&
                    (r_rd[k] == src_idx[i*IDX_W +: IDX_W])) begin
                    w_sel[i]     = FWD_W'(k);
                    w_src_haz[i] = (r_rem[k] != '0);
                end
            end
        end
    end

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[i*FWD_W +: FWD_W] = w_sel[i];
        end
    end

    assign w_lat_zero = (issue_lat == '0);
    assign w_lat_high = ({1'b0, issue_lat} > LP_DEPTH);
    assign w_lat_eff  = w_lat_zero ? LAT_W'(1) : (w_lat_high ? LP_DEPTH[LAT_W-1:0] : issue_lat);
    assign w_rem_new  = w_lat_eff - LAT_W'(1);

    assign w_stall  = ~flush & (ex_hold | (issue_valid & (|w_src_haz)));
    assign w_push   = issue_valid & issue_reg_wr & (issue_rd != '0) & ~w_stall & ~flush;

    assign stall     = w_stall;
    assign pc_en     = ~w_stall;
    assign if_id_en  = ~w_stall;
    assign stall_cnt = r_stall_cnt;
    assign lat_err   = r_lat_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                r_v[k]   <= 1'b0;
                r_rd[k]  <= '0;
                r_rem[k] <= '0;
            end
            r_stall_cnt <= '0;
            r_lat_err   <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (issue_valid && issue_reg_wr && (w_lat_zero || w_lat_high)) begin
                r_lat_err <= 1'b1;
            end
            if (!ex_hold) begin
                for (int k = PIPE_DEPTH; k >= 2; k--) begin
                    r_v[k]   <= r_v[k-1];
                    r_rd[k]  <= r_rd[k-1];
                    r_rem[k] <= (r_rem[k-1] == '0) ? '0 : r_rem[k-1] - LAT_W'(1);
                end
                r_v[1]   <= w_push;
                r_rd[1]  <= w_push ? issue_rd : '0;
                r_rem[1] <= w_push ? w_rem_new : '0;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - directed self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_reg_wr, flush, ex_hold;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_lat;
    logic [9:0]  src_idx;
    logic [1:0]  src_used;
    logic        stall, pc_en, if_id_en, lat_err;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cnt;
    logic        s2_stall, s2_pc_en, s2_if_id_en, s2_lat_err;
    logic [3:0]  s2_fwd_sel;
    logic [31:0] s2_stall_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_reg_wr(issue_reg_wr),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src_idx(src_idx), .src_used(src_used),
        .flush(flush), .ex_hold(ex_hold), .stall(stall), .pc_en(pc_en), .if_id_en(if_id_en),
        .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .lat_err(lat_err)
    );

    id_hazard_scoreboard #(.PIPE_DEPTH(2), .FWD_W(2)) dut2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_reg_wr(issue_reg_wr),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .src_idx(src_idx), .src_used(src_used),
        .flush(flush), .ex_hold(ex_hold), .stall(s2_stall), .pc_en(s2_pc_en), .if_id_en(s2_if_id_en),
        .fwd_sel(s2_fwd_sel), .stall_cnt(s2_stall_cnt), .lat_err(s2_lat_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic [4:0] rd, input logic [1:0] lat,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        issue_valid  = v;
        issue_reg_wr = wr;
        issue_rd     = rd;
        issue_lat    = lat;
        src_idx      = {s1, s0};
        src_used     = used;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 5'd0, 2'd1, 5'd0, 5'd0, 2'b00);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd1, 5'd0, 5'd0, 2'b00);
        #10;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if ({pc_en, if_id_en} !== 2'b11) begin failures++; $display("FAIL reset_en got=%b exp=11", {pc_en, if_id_en}); end
        checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=0000", fwd_sel); end
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (lat_err !== 1'b0) begin failures++; $display("FAIL reset_laterr got=%0b exp=0", lat_err); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_alu_chain();
        drive(1'b1, 1'b1, 5'd5, 2'd1, 5'd0, 5'd0, 2'b00);
        tick();
        drive(1'b1, 1'b1, 5'd6, 2'd1, 5'd5, 5'd5, 2'b11);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0101) begin failures++; $display("FAIL alu_fwd got=%b exp=0101", fwd_sel); end
        tick();
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1'b1, 1'b1, 5'd7, 2'd2, 5'd0, 5'd0, 2'b00);
        tick();
        drive(1'b1, 1'b1, 5'd8, 2'd1, 5'd7, 5'd0, 2'b11);
        checks++; if (stall !== 1'b1 || pc_en !== 1'b0) begin failures++; $display("FAIL lu_stall1 got=%0b/%0b exp=1/0", stall, pc_en); end
        checks++; if (fwd_sel !== 4'b0001) begin failures++; $display("FAIL lu_fwd1 got=%b exp=0001", fwd_sel); end
        tick();
        exp_cnt = exp_cnt + 1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall2 got=%0b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0010) begin failures++; $display("FAIL lu_fwd2 got=%b exp=0010", fwd_sel); end
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'd1, 5'd7, 5'd8, 2'b11);
        checks++; if (fwd_sel !== 4'b0111) begin failures++; $display("FAIL lu_bubble got=%b exp=0111", fwd_sel); end
        idle(3);
    endtask

    task automatic test_multi_writer();
        drive(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b1, 5'd4, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b0, 5'd0, 2'd1, 5'd3, 5'd4, 2'b11);
        checks++; if (fwd_sel !== 4'b1001) begin failures++; $display("FAIL multi_fwd got=%b exp=1001", fwd_sel); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL multi_stall got=%0b exp=0", stall); end
        idle(3);
    endtask

    task automatic test_x0_unused();
        drive(1'b1, 1'b1, 5'd0, 2'd2, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b1, 5'd9, 2'd2, 5'd0, 5'd0, 2'b11);
        checks++; if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin failures++; $display("FAIL x0_read got=%b/%0b exp=0000/0", fwd_sel, stall); end
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd1, 5'd9, 5'd9, 2'b00);
        checks++; if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin failures++; $display("FAIL unused_read got=%b/%0b exp=0000/0", fwd_sel, stall); end
        tick(); tick();
        drive(1'b1, 1'b0, 5'd0, 2'd1, 5'd9, 5'd0, 2'b01);
        checks++; if (fwd_sel !== 4'b0011) begin failures++; $display("FAIL wb_fwd got=%b exp=0011", fwd_sel); end
        tick();
        checks++; if (fwd_sel !== 4'b0000) begin failures++; $display("FAIL retired got=%b exp=0000", fwd_sel); end
        idle(3);
    endtask

    task automatic test_flush_hold();
        drive(1'b1, 1'b1, 5'd7, 2'd2, 5'd0, 5'd0, 2'b00); tick();
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd8, 2'd1, 5'd7, 5'd0, 2'b11);
        checks++; if (stall !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL flush_stall got=%0b/%0b exp=0/1", stall, pc_en); end
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd1, 5'd7, 5'd8, 2'b11);
        checks++; if (fwd_sel !== 4'b0010) begin failures++; $display("FAIL flush_noentry got=%b exp=0010", fwd_sel); end
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        ex_hold = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stall !== 1'b1 || fwd_sel !== 4'b0010) begin failures++; $display("FAIL hold_%0d got=%0b/%b exp=1/0010", i, stall, fwd_sel); end
            tick();
        end
        exp_cnt = exp_cnt + 3;
        ex_hold = 1'b0; #1;
        checks++; if (stall !== 1'b0 || fwd_sel !== 4'b0010) begin failures++; $display("FAIL hold_frozen got=%0b/%b exp=0/0010", stall, fwd_sel); end
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL hold_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        tick();
        checks++; if (fwd_sel !== 4'b0011) begin failures++; $display("FAIL hold_release got=%b exp=0011", fwd_sel); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd1, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b1, 5'd2, 2'd1, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b1, 5'd3, 2'd3, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b0, 5'd0, 2'd1, 5'd1, 5'd3, 2'b11);
        checks++; if (stall !== 1'b1 || fwd_sel !== 4'b0111) begin failures++; $display("FAIL mid_pre got=%0b/%b exp=1/0111", stall, fwd_sel); end
        checks++; if (stall_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL mid_precnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        checks++; if (lat_err !== 1'b0 || s2_lat_err !== 1'b1) begin failures++; $display("FAIL mid_laterr got=%0b/%0b exp=0/1", lat_err, s2_lat_err); end
        #1 rst = 1'b1; #1;
        checks++; if (stall !== 1'b0 || fwd_sel !== 4'b0000) begin failures++; $display("FAIL mid_rst got=%0b/%b exp=0/0000", stall, fwd_sel); end
        checks++; if (stall_cnt !== 32'd0 || s2_lat_err !== 1'b0) begin failures++; $display("FAIL mid_rstcnt got=%0d/%0b exp=0/0", stall_cnt, s2_lat_err); end
        idle(1);
        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 2'd3, 5'd0, 5'd0, 2'b00); tick();
        checks++; if (s2_lat_err !== 1'b1 || lat_err !== 1'b0) begin failures++; $display("FAIL laterr_set got=%0b/%0b exp=1/0", s2_lat_err, lat_err); end
        idle(2);
        checks++; if (s2_lat_err !== 1'b1) begin failures++; $display("FAIL laterr_sticky got=%0b exp=1", s2_lat_err); end
        drive(1'b1, 1'b1, 5'd10, 2'd0, 5'd0, 5'd0, 2'b00); tick();
        drive(1'b1, 1'b0, 5'd0, 2'd1, 5'd10, 5'd0, 2'b01);
        checks++; if (lat_err !== 1'b1) begin failures++; $display("FAIL laterr_zero got=%0b exp=1", lat_err); end
        checks++; if (stall !== 1'b0 || fwd_sel !== 4'b0001) begin failures++; $display("FAIL lat0_as1 got=%0b/%b exp=0/0001", stall, fwd_sel); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_multi_writer();
        test_x0_unused();
        test_flush_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
